mem_arbiter: RTL and testbench

//  Shares the single 8-bit synchronous memory port between two requesters:

---
 rtl/mem_arbiter_pkg.sv | 33 +++
 rtl/rr_pick2.sv | 24 ++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: owner states, read-return tags,
// default bus widths and the grant-to-owner decode.
package mem_arbiter_pkg;

    localparam int unsigned MEM_ADDR_W = 8;
    localparam int unsigned MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'b00,
        OWN_A    = 2'b01,
        OWN_B    = 2'b10
    } owner_e;

    typedef enum logic {
        TAG_A = 1'b0,
        TAG_B = 1'b1
    } port_tag_e;

    typedef struct packed {
        logic      valid;
        port_tag_e port;
    } rd_tag_t;

    // One-hot grant {B, A} to the owner it establishes.
    function automatic owner_e owner_of(input logic [1:0] gnt);
        case (gnt)
            2'b01:   return OWN_A;
            2'b10:   return OWN_B;
            default: return OWN_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: one-hot grant {B, A} from the
// requests, the last-granted pointer and a burst-hold request.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_b,
    input  logic       hold,
    output logic [1:0] gnt
);

    logic pick_b;

    always_comb begin
        gnt    = '0;
        // On a tie the last winner keeps the port only while hold is asserted.
        pick_b = hold ? last_b : ~last_b;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = pick_b ? 2'b10 : 2'b01;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the shared synchronous memory port.
// Optional owner bursting on ties is enabled by defining MEM_ARB_BURST_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = MEM_ADDR_W,
    parameter int unsigned DATA_W    = MEM_DATA_W,
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_write,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic              b_write,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] to_mem,
    output logic              mem_write,
    input  logic [DATA_W-1:0] from_mem
);

    owner_e    state_q, state_d;
    logic      last_b_q, last_b_d;
    logic [1:0] pick;
    logic      burst_hold;
    logic      issue_read;
    rd_tag_t   rd_pipe [READ_LAT];
    rd_tag_t   rd_ret;

    rr_pick2 u_pick (
        .req    ({b_req, a_req}),
        .last_b (last_b_q),
        .hold   (burst_hold),
        .gnt    (pick)
    );

`ifdef MEM_ARB_BURST_EN
    localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

    logic [BEAT_W-1:0] beats_q;

    assign burst_hold = (state_q != OWN_IDLE) && (beats_q < BEAT_W'(MAX_BURST));

    // Counts consecutive grants to the current owner, saturating at MAX_BURST.
    always_ff @(posedge clock) begin
        if (reset) begin
            beats_q <= '0;
        end else if (pick == 2'b00) begin
            beats_q <= '0;
        end else if (state_d != state_q) begin
            beats_q <= BEAT_W'(1);
        end else if (beats_q < BEAT_W'(MAX_BURST)) begin
            beats_q <= beats_q + BEAT_W'(1);
        end
    end
`else
    logic unused_max_burst;

    assign burst_hold       = 1'b0;
    assign unused_max_burst = ^MAX_BURST;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= OWN_IDLE;
            last_b_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
        end
    end

    always_comb begin
        state_d  = owner_of(pick);
        last_b_d = last_b_q;
        if (state_d == OWN_A) begin
            last_b_d = 1'b0;
        end else if (state_d == OWN_B) begin
            last_b_d = 1'b1;
        end
    end

    // Issue stage: the winner's request is registered onto the memory port.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            mem_write <= 1'b0;
            address   <= '0;
            to_mem    <= '0;
        end else begin
            a_gnt     <= pick[0];
            b_gnt     <= pick[1];
            mem_write <= (pick[0] & a_write) | (pick[1] & b_write);
            if (pick[0]) begin
                address <= a_addr;
                to_mem  <= a_wdata;
            end else if (pick[1]) begin
                address <= b_addr;
                to_mem  <= b_wdata;
            end
        end
    end

    assign issue_read = (a_gnt | b_gnt) & ~mem_write;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < READ_LAT; i++) begin
                rd_pipe[i] <= '0;
            end
        end else begin
            rd_pipe[0] <= '{valid: issue_read, port: (b_gnt ? TAG_B : TAG_A)};
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign rd_ret   = rd_pipe[READ_LAT-1];
    assign a_rvalid = rd_ret.valid && (rd_ret.port == TAG_A);
    assign b_rvalid = rd_ret.valid && (rd_ret.port == TAG_B);
    assign a_rdata  = a_rvalid ? from_mem : '0;
    assign b_rdata  = b_rvalid ? from_mem : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a read-return scoreboard; one instance
// at READ_LAT=1 and one at READ_LAT=3, each behind a small memory model.
module tb_mem_arbiter;

    typedef struct packed {
        logic       port;
        logic [7:0] data;
    } exp_t;

    logic       clock, reset;
    logic       a_req, a_write, b_req, b_write;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid, mem_write;
    logic [7:0] a_rdata, b_rdata, address, to_mem, from_mem;

    logic       a3_req, a3_write, b3_req, b3_write;
    logic [7:0] a3_addr, a3_wdata, b3_addr, b3_wdata;
    logic       a3_gnt, a3_rvalid, b3_gnt, b3_rvalid, mem_write3;
    logic [7:0] a3_rdata, b3_rdata, address3, to_mem3, from_mem3;

    logic [7:0] mem1 [256];
    logic [7:0] mem3 [256];
    logic [7:0] rd1, p1, p2, p3;

    exp_t q1[$];
    exp_t q3[$];
    int   checks;
    int   failures;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LAT(1), .MAX_BURST(4)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .address(address), .to_mem(to_mem), .mem_write(mem_write), .from_mem(from_mem)
    );

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LAT(3), .MAX_BURST(4)) dut3 (
        .clock(clock), .reset(reset),
        .a_req(a3_req), .a_write(a3_write), .a_addr(a3_addr), .a_wdata(a3_wdata),
        .a_gnt(a3_gnt), .a_rdata(a3_rdata), .a_rvalid(a3_rvalid),
        .b_req(b3_req), .b_write(b3_write), .b_addr(b3_addr), .b_wdata(b3_wdata),
        .b_gnt(b3_gnt), .b_rdata(b3_rdata), .b_rvalid(b3_rvalid),
        .address(address3), .to_mem(to_mem3), .mem_write(mem_write3), .from_mem(from_mem3)
    );

    function automatic logic [7:0] mem_init(input logic [7:0] a);
        return a ^ 8'h4A;
    endfunction

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory models: latency 1 and latency 3, contents restored on reset.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem1[i] <= mem_init(8'(i));
            rd1 <= '0;
        end else begin
            if (mem_write) mem1[address] <= to_mem;
            rd1 <= mem1[address];
        end
    end
    assign from_mem = rd1;

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem3[i] <= mem_init(8'(i));
            p1 <= '0;
            p2 <= '0;
            p3 <= '0;
        end else begin
            if (mem_write3) mem3[address3] <= to_mem3;
            p1 <= mem3[address3];
            p2 <= p1;
            p3 <= p2;
        end
    end
    assign from_mem3 = p3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check();
        exp_t e;
        chk("one_rvalid_l1", 32'(a_rvalid & b_rvalid), 0);
        chk("one_rvalid_l3", 32'(a3_rvalid & b3_rvalid), 0);
        if (a_rvalid === 1'b1 || b_rvalid === 1'b1) begin
            chk("rvalid_expected_l1", 32'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("rd_port_l1", 32'(b_rvalid), 32'(e.port));
                chk("rd_data_l1", 32'(e.port ? b_rdata : a_rdata), 32'(e.data));
            end
        end
        if (a3_rvalid === 1'b1 || b3_rvalid === 1'b1) begin
            chk("rvalid_expected_l3", 32'(q3.size() > 0), 1);
            if (q3.size() > 0) begin
                e = q3.pop_front();
                chk("rd_port_l3", 32'(b3_rvalid), 32'(e.port));
                chk("rd_data_l3", 32'(e.port ? b3_rdata : a3_rdata), 32'(e.data));
            end
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        sb_check();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_req = 1'b0;
        b_req = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    function automatic logic exp_port(input int k);
`ifdef MEM_ARB_BURST_EN
        return 1'((k / 4) % 2);
`else
        return 1'(k % 2);
`endif
    endfunction

    initial begin
        int ia, ib;
        logic p;
        checks = 0;
        failures = 0;
        reset = 1'b1;
        a_req = 0; a_write = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_write = 0; b_addr = '0; b_wdata = '0;
        a3_req = 0; a3_write = 0; a3_addr = '0; a3_wdata = '0;
        b3_req = 0; b3_write = 0; b3_addr = '0; b3_wdata = '0;

        // Reset state
        cycle();
        cycle();
        chk("rst_a_gnt", 32'(a_gnt), 0);
        chk("rst_b_gnt", 32'(b_gnt), 0);
        chk("rst_mem_write", 32'(mem_write), 0);
        chk("rst_address", 32'(address), 0);
        chk("rst_to_mem", 32'(to_mem), 0);
        chk("rst_a_rvalid", 32'(a_rvalid), 0);

        // 1: lone A read of 0x10
        reset = 1'b0;
        a_req = 1; a_write = 0; a_addr = 8'h10;
        q1.push_back('{port: 1'b0, data: 8'h5A});
        cycle();
        chk("t1_a_gnt", 32'(a_gnt), 1);
        chk("t1_b_gnt", 32'(b_gnt), 0);
        chk("t1_address", 32'(address), 32'h10);
        chk("t1_mem_write", 32'(mem_write), 0);
        a_req = 0;
        cycle();
        chk("t1_a_rvalid", 32'(a_rvalid), 1);
        chk("t1_a_rdata", 32'(a_rdata), 32'h5A);
        chk("t1_b_rvalid", 32'(b_rvalid), 0);
        chk("t1_a_gnt_off", 32'(a_gnt), 0);
        chk("t1_addr_hold", 32'(address), 32'h10);

        // 2: both ports request continuously from reset
        do_reset();
        ia = 0; ib = 0;
        for (int k = 0; k < 8; k++) begin
            if (exp_port(k)) begin
                q1.push_back('{port: 1'b1, data: mem_init(8'h40 + 8'(ib))});
                ib++;
            end else begin
                q1.push_back('{port: 1'b0, data: mem_init(8'h20 + 8'(ia))});
                ia++;
            end
        end
        ia = 0; ib = 0;
        a_req = 1; a_write = 0; a_addr = 8'h20;
        b_req = 1; b_write = 0; b_addr = 8'h40;
        for (int k = 0; k < 8; k++) begin
            cycle();
            p = exp_port(k);
            chk("t2_a_gnt", 32'(a_gnt), 32'(!p));
            chk("t2_b_gnt", 32'(b_gnt), 32'(p));
            chk("t2_address", 32'(address), p ? 32'(8'h40 + 8'(ib)) : 32'(8'h20 + 8'(ia)));
            if (p) begin
                ib++;
                b_addr = 8'h40 + 8'(ib);
            end else begin
                ia++;
                a_addr = 8'h20 + 8'(ia);
            end
        end
        a_req = 0; b_req = 0;
        cycle();
        cycle();

`ifdef MEM_ARB_BURST_EN
        // 4b: A drops its request after two beats, B takes over at once
        do_reset();
        a_req = 1; a_addr = 8'h50; b_req = 1; b_addr = 8'h60;
        q1.push_back('{port: 1'b0, data: mem_init(8'h50)});
        q1.push_back('{port: 1'b0, data: mem_init(8'h50)});
        q1.push_back('{port: 1'b1, data: mem_init(8'h60)});
        cycle();
        chk("t4_beat1_a", 32'(a_gnt), 1);
        cycle();
        chk("t4_beat2_a", 32'(a_gnt), 1);
        a_req = 0;
        cycle();
        chk("t4_switch_b", 32'(b_gnt), 1);
        chk("t4_switch_a", 32'(a_gnt), 0);
        b_req = 0;
        cycle();
        cycle();
`endif

        // 3: B write then A read of the same location, A alone back-to-back
        do_reset();
        b_req = 1; b_write = 1; b_addr = 8'h30; b_wdata = 8'h22;
        cycle();
        chk("t3_b_gnt", 32'(b_gnt), 1);
        chk("t3_wr_en", 32'(mem_write), 1);
        chk("t3_wr_addr", 32'(address), 32'h30);
        chk("t3_wr_data", 32'(to_mem), 32'h22);
        b_req = 0; b_write = 0;
        a_req = 1; a_write = 0; a_addr = 8'h30;
        q1.push_back('{port: 1'b0, data: 8'h22});
        cycle();
        chk("t3_a_gnt", 32'(a_gnt), 1);
        chk("t3_wr_off", 32'(mem_write), 0);
        chk("t3_b_gnt_off", 32'(b_gnt), 0);
        a_addr = 8'h31;
        q1.push_back('{port: 1'b0, data: mem_init(8'h31)});
        cycle();
        chk("t3_a_gnt_b2b", 32'(a_gnt), 1);
        chk("t3_address2", 32'(address), 32'h31);
        a_req = 0;
        cycle();
        chk("t3_idle_gnt", 32'(a_gnt | b_gnt), 0);
        chk("t3_idle_wr", 32'(mem_write), 0);
        chk("t3_idle_addr", 32'(address), 32'h31);
        cycle();

        // 5: reset while a read is in flight
        do_reset();
        a_req = 1; a_write = 0; a_addr = 8'h70; a_wdata = 8'hEE;
        cycle();
        chk("t5_a_gnt", 32'(a_gnt), 1);
        reset = 1; a_req = 0; a_wdata = '0;
        cycle();
        chk("t5_no_rvalid", 32'(a_rvalid), 0);
        chk("t5_a_gnt", 32'(a_gnt), 0);
        chk("t5_address", 32'(address), 0);
        chk("t5_to_mem", 32'(to_mem), 0);
        chk("t5_mem_write", 32'(mem_write), 0);
        chk("t5_a_rdata", 32'(a_rdata), 0);
        reset = 0;
        a_req = 1; a_addr = 8'h71; b_req = 1; b_addr = 8'h72;
        q1.push_back('{port: 1'b0, data: mem_init(8'h71)});
        cycle();
        chk("t5_tie_a", 32'(a_gnt), 1);
        chk("t5_tie_b", 32'(b_gnt), 0);
        a_req = 0; b_req = 0;
        cycle();
        chk("t5_b_dropped", 32'(b_gnt), 0);
        cycle();

        // 6: READ_LAT=3 back-to-back reads, B write while they are in flight
        a3_req = 1; a3_write = 0; a3_addr = 8'h01;
        q3.push_back('{port: 1'b0, data: mem_init(8'h01)});
        cycle();
        chk("t6_gnt0", 32'(a3_gnt), 1);
        chk("t6_addr0", 32'(address3), 32'h01);
        chk("t6_rv_n0", 32'(a3_rvalid), 0);
        a3_addr = 8'h02;
        q3.push_back('{port: 1'b0, data: mem_init(8'h02)});
        cycle();
        chk("t6_addr1", 32'(address3), 32'h02);
        chk("t6_rv_n1", 32'(a3_rvalid), 0);
        a3_addr = 8'h03;
        q3.push_back('{port: 1'b0, data: mem_init(8'h03)});
        cycle();
        chk("t6_addr2", 32'(address3), 32'h03);
        chk("t6_rv_n2", 32'(a3_rvalid), 0);
        a3_req = 0;
        b3_req = 1; b3_write = 1; b3_addr = 8'h01; b3_wdata = 8'h99;
        cycle();
        chk("t6_rv_n3", 32'(a3_rvalid), 1);
        chk("t6_b_wr_gnt", 32'(b3_gnt), 1);
        chk("t6_b_wr_en", 32'(mem_write3), 1);
        b3_req = 0; b3_write = 0;
        cycle();
        chk("t6_rv_n4", 32'(a3_rvalid), 1);
        chk("t6_wr_off", 32'(mem_write3), 0);
        cycle();
        chk("t6_rv_n5", 32'(a3_rvalid), 1);
        a3_req = 1; a3_addr = 8'h01;
        q3.push_back('{port: 1'b0, data: 8'h99});
        cycle();
        chk("t6_rv_n6", 32'(a3_rvalid), 0);
        chk("t6_b_rv", 32'(b3_rvalid), 0);
        a3_req = 0;
        for (int k = 0; k < 4; k++) cycle();

        chk("sb_drain_l1", q1.size(), 0);
        chk("sb_drain_l3", q3.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
